// File: rtl/core_pkg.sv
// Core-wide widths, PC control encodings and the EXE->PC payload type.
package core_pkg;

    localparam int unsigned ADDR_WIDTH    = 32;
    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned PC_CTRL_WIDTH = 3;

    typedef logic [PC_CTRL_WIDTH-1:0] pc_ctrl_t;

    // Encodings not listed here fall back to sequential (PC_INC) behaviour.
    localparam pc_ctrl_t PC_INC  = 3'd0;
    localparam pc_ctrl_t PC_SET  = 3'd1;
    localparam pc_ctrl_t PC_ADD  = 3'd2;
    localparam pc_ctrl_t PC_COND = 3'd3;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] exe_out;
        logic [DATA_WIDTH-1:0] op3;
        pc_ctrl_t              pc_ctrl;
    } exe2pc_t;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the fetch PC, advances it while fetch
// accepts addresses, and resolves EXE control-flow payloads into redirects
// (flush + bubble) or a sticky halt on a misaligned target.
module pc_sequencer
    import core_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] START_ADDR    = '0,
    parameter int unsigned           BUBBLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exe2pc_valid_i,
    input  exe2pc_t               exe2pc_i,
    output logic                  exe2pc_ready_o,
    input  logic                  fetch_ready_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  pc_valid_o,
    output logic                  flush_o,
    output logic                  misaligned_o
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        BUBBLE,
        HALT
    } state_t;

    localparam logic [3:0] BUBBLE_LOAD = 4'(BUBBLE_CYCLES);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [3:0]            bubble_cnt;
    logic [3:0]            bubble_next;
    logic                  flush;
    logic                  flush_next;
    logic                  misaligned;
    logic                  misaligned_next;
    logic                  active;
    logic                  active_next;

    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] seq_target;
    logic [ADDR_WIDTH-1:0] target;
    logic                  accept;
    logic                  redirect;

    // Resolve the payload's pc_ctrl into a target address relative to its own pc.
    always_comb begin
        base       = exe2pc_i.pc;
        seq_target = base + ADDR_WIDTH'(4);
        case (exe2pc_i.pc_ctrl)
            PC_SET:  target = {exe2pc_i.exe_out[ADDR_WIDTH-1:1], 1'b0};
            PC_ADD:  target = base + exe2pc_i.exe_out[ADDR_WIDTH-1:0];
            PC_COND: target = exe2pc_i.exe_out[0] ? base + exe2pc_i.op3[ADDR_WIDTH-1:0]
                                                  : seq_target;
            default: target = seq_target;
        endcase
        accept   = exe2pc_valid_i && active;
        redirect = (target != seq_target);
    end

    // Next-state and next-output decode; a redirect takes priority over the sequential +4.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        bubble_next     = bubble_cnt;
        flush_next      = 1'b0;
        misaligned_next = misaligned;
        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (accept && redirect) begin
                    flush_next = 1'b1;
                    if (target[1:0] != 2'b00) begin
                        misaligned_next = 1'b1;
                        state_next      = HALT;
                    end else begin
                        pc_next     = target;
                        bubble_next = BUBBLE_LOAD;
                        state_next  = BUBBLE;
                    end
                end else if (fetch_ready_i) begin
                    pc_next = pc + ADDR_WIDTH'(4);
                end
            end
            BUBBLE: begin
                bubble_next = bubble_cnt - 4'd1;
                if (bubble_cnt <= 4'd1) begin
                    state_next = RUN;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
        // Valid and ready are registered copies of "next state is RUN", so they
        // depend on state alone and never on the incoming handshake.
        active_next = (state_next == RUN);
    end

    // State and registered outputs; reset forces BOOT and the start address at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= START_ADDR;
            bubble_cnt <= '0;
            flush      <= 1'b0;
            misaligned <= 1'b0;
            active     <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            bubble_cnt <= bubble_next;
            flush      <= flush_next;
            misaligned <= misaligned_next;
            active     <= active_next;
        end
    end

    assign pc_o           = pc;
    assign pc_valid_o     = active;
    assign exe2pc_ready_o = active;
    assign flush_o        = flush;
    assign misaligned_o   = misaligned;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each task queues per-cycle stimulus with
// the outputs required after that edge, then drives and checks it inline.
module tb_pc_sequencer;
    import core_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        ready;
        logic        flush;
        logic        mis;
    } obs_t;

    typedef struct packed {
        logic        v;
        logic [2:0]  ctrl;
        logic [31:0] base;
        logic [31:0] eo;
        logic [31:0] o3;
        logic        fr;
        obs_t        exp;
    } row_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exe2pc_valid = 1'b0;
    exe2pc_t     exe2pc = '0;
    logic        exe2pc_ready;
    logic        fetch_ready = 1'b0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        misaligned;

    int tests_run    = 0;
    int tests_failed = 0;

    row_t plan[$];
    obs_t sb[$];

    pc_sequencer #(
        .START_ADDR   (32'h0000_1000),
        .BUBBLE_CYCLES(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .exe2pc_valid_i(exe2pc_valid),
        .exe2pc_i      (exe2pc),
        .exe2pc_ready_o(exe2pc_ready),
        .fetch_ready_i (fetch_ready),
        .pc_o          (pc),
        .pc_valid_o    (pc_valid),
        .flush_o       (flush),
        .misaligned_o  (misaligned)
    );

    always #5 clk = ~clk;

    task automatic sched(input logic v, input logic [2:0] ctrl, input logic [31:0] base,
                         input logic [31:0] eo, input logic [31:0] o3, input logic fr,
                         input logic [31:0] epc, input logic ev, input logic er,
                         input logic ef, input logic em);
        row_t r;
        r.v    = v;
        r.ctrl = ctrl;
        r.base = base;
        r.eo   = eo;
        r.o3   = o3;
        r.fr   = fr;
        r.exp  = {epc, ev, er, ef, em};
        plan.push_back(r);
    endtask

    task automatic apply(input row_t r);
        exe2pc_valid   = r.v;
        exe2pc.pc_ctrl = r.ctrl;
        exe2pc.pc      = r.base;
        exe2pc.exe_out = r.eo;
        exe2pc.op3     = r.o3;
        fetch_ready    = r.fr;
    endtask

    task automatic test_reset();
        obs_t got;
        obs_t want;
        row_t r;
        int   step = 0;
        repeat (2) @(posedge clk);
        #1;
        got  = {pc, pc_valid, exe2pc_ready, flush, misaligned};
        want = {32'h1000, 4'b0000};
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL reset_state: got %h required %h", got, want);
        end
        rst = 1'b0;
        fetch_ready = 1'b1;
        #1;
        got = {pc, pc_valid, exe2pc_ready, flush, misaligned};
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL boot_cycle: got %h required %h", got, want);
        end
        sched(0, PC_INC, 0, 0, 0, 1, 32'h1000, 1, 1, 0, 0);
        sched(0, PC_INC, 0, 0, 0, 1, 32'h1004, 1, 1, 0, 0);
        sched(0, PC_INC, 0, 0, 0, 1, 32'h1008, 1, 1, 0, 0);
        sched(0, PC_INC, 0, 0, 0, 1, 32'h100C, 1, 1, 0, 0);
        while (plan.size() > 0) begin
            r = plan.pop_front();
            apply(r);
            sb.push_back(r.exp);
            @(posedge clk);
            #1;
            got  = {pc, pc_valid, exe2pc_ready, flush, misaligned};
            want = sb.pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL boot_seq step %0d: got pc=%h v=%b r=%b f=%b m=%b required pc=%h v=%b r=%b f=%b m=%b",
                         step, got.pc, got.valid, got.ready, got.flush, got.mis,
                         want.pc, want.valid, want.ready, want.flush, want.mis);
            end
            step++;
        end
    endtask

    task automatic test_redirect();
        obs_t got;
        obs_t want;
        row_t r;
        int   step = 0;
        // taken branch with simultaneous fetch_ready; next payload held through the bubble
        sched(1, PC_COND, 32'h1008, 32'h1,    32'h40, 1, 32'h1048, 0, 0, 1, 0);
        sched(1, PC_SET,  32'h1048, 32'h3000, 32'h0,  1, 32'h1048, 0, 0, 0, 0);
        sched(1, PC_SET,  32'h1048, 32'h3000, 32'h0,  1, 32'h1048, 1, 1, 0, 0);
        sched(1, PC_SET,  32'h1048, 32'h3000, 32'h0,  1, 32'h3000, 0, 0, 1, 0);
        sched(0, PC_INC,  32'h0,    32'h0,    32'h0,  1, 32'h3000, 0, 0, 0, 0);
        sched(0, PC_INC,  32'h0,    32'h0,    32'h0,  1, 32'h3000, 1, 1, 0, 0);
        sched(0, PC_INC,  32'h0,    32'h0,    32'h0,  1, 32'h3004, 1, 1, 0, 0);
        while (plan.size() > 0) begin
            r = plan.pop_front();
            apply(r);
            sb.push_back(r.exp);
            @(posedge clk);
            #1;
            got  = {pc, pc_valid, exe2pc_ready, flush, misaligned};
            want = sb.pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL redirect step %0d: got pc=%h v=%b r=%b f=%b m=%b required pc=%h v=%b r=%b f=%b m=%b",
                         step, got.pc, got.valid, got.ready, got.flush, got.mis,
                         want.pc, want.valid, want.ready, want.flush, want.mis);
            end
            step++;
        end
    endtask

    task automatic test_back_to_back();
        obs_t got;
        obs_t want;
        row_t r;
        int   step = 0;
        // non-redirecting payloads every cycle: sequential progress continues
        sched(1, PC_COND, 32'h1008, 32'h0,    32'h40, 1, 32'h3008, 1, 1, 0, 0);
        sched(1, PC_INC,  32'h1008, 32'h0,    32'h0,  1, 32'h300C, 1, 1, 0, 0);
        sched(1, 3'd7,    32'h1008, 32'h5000, 32'h0,  1, 32'h3010, 1, 1, 0, 0);
        sched(1, PC_ADD,  32'h1008, 32'h4,    32'h0,  1, 32'h3014, 1, 1, 0, 0);
        sched(1, PC_COND, 32'h1008, 32'h0,    32'h40, 0, 32'h3014, 1, 1, 0, 0);
        sched(0, PC_INC,  32'h0,    32'h0,    32'h0,  1, 32'h3018, 1, 1, 0, 0);
        while (plan.size() > 0) begin
            r = plan.pop_front();
            apply(r);
            sb.push_back(r.exp);
            @(posedge clk);
            #1;
            got  = {pc, pc_valid, exe2pc_ready, flush, misaligned};
            want = sb.pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL back_to_back step %0d: got pc=%h v=%b r=%b f=%b m=%b required pc=%h v=%b r=%b f=%b m=%b",
                         step, got.pc, got.valid, got.ready, got.flush, got.mis,
                         want.pc, want.valid, want.ready, want.flush, want.mis);
            end
            step++;
        end
    endtask

    task automatic test_wrap();
        obs_t got;
        obs_t want;
        row_t r;
        int   step = 0;
        sched(1, PC_ADD, 32'hFFFF_FFF0, 32'h20,        32'h0, 1, 32'h0000_0010, 0, 0, 1, 0);
        sched(0, PC_INC, 32'h0,         32'h0,         32'h0, 1, 32'h0000_0010, 0, 0, 0, 0);
        sched(0, PC_INC, 32'h0,         32'h0,         32'h0, 1, 32'h0000_0010, 1, 1, 0, 0);
        sched(1, PC_SET, 32'h10,        32'hFFFF_FFFD, 32'h0, 1, 32'hFFFF_FFFC, 0, 0, 1, 0);
        sched(0, PC_INC, 32'h0,         32'h0,         32'h0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        sched(0, PC_INC, 32'h0,         32'h0,         32'h0, 1, 32'hFFFF_FFFC, 1, 1, 0, 0);
        sched(0, PC_INC, 32'h0,         32'h0,         32'h0, 1, 32'h0000_0000, 1, 1, 0, 0);
        sched(0, PC_INC, 32'h0,         32'h0,         32'h0, 1, 32'h0000_0004, 1, 1, 0, 0);
        while (plan.size() > 0) begin
            r = plan.pop_front();
            apply(r);
            sb.push_back(r.exp);
            @(posedge clk);
            #1;
            got  = {pc, pc_valid, exe2pc_ready, flush, misaligned};
            want = sb.pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL wrap step %0d: got pc=%h v=%b r=%b f=%b m=%b required pc=%h v=%b r=%b f=%b m=%b",
                         step, got.pc, got.valid, got.ready, got.flush, got.mis,
                         want.pc, want.valid, want.ready, want.flush, want.mis);
            end
            step++;
        end
    endtask

    task automatic test_misaligned();
        obs_t got;
        obs_t want;
        row_t r;
        int   step = 0;
        sched(1, PC_SET, 32'h4,    32'h2001, 32'h0, 1, 32'h2000, 0, 0, 1, 0);
        sched(0, PC_INC, 32'h0,    32'h0,    32'h0, 1, 32'h2000, 0, 0, 0, 0);
        sched(0, PC_INC, 32'h0,    32'h0,    32'h0, 1, 32'h2000, 1, 1, 0, 0);
        sched(1, PC_SET, 32'h2000, 32'h2002, 32'h0, 1, 32'h2000, 0, 0, 1, 1);
        sched(1, PC_SET, 32'h2000, 32'h7000, 32'h0, 1, 32'h2000, 0, 0, 0, 1);
        sched(1, PC_ADD, 32'h2000, 32'h40,   32'h0, 1, 32'h2000, 0, 0, 0, 1);
        sched(0, PC_INC, 32'h0,    32'h0,    32'h0, 1, 32'h2000, 0, 0, 0, 1);
        sched(1, PC_INC, 32'h2000, 32'h0,    32'h0, 1, 32'h2000, 0, 0, 0, 1);
        while (plan.size() > 0) begin
            r = plan.pop_front();
            apply(r);
            sb.push_back(r.exp);
            @(posedge clk);
            #1;
            got  = {pc, pc_valid, exe2pc_ready, flush, misaligned};
            want = sb.pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL misaligned step %0d: got pc=%h v=%b r=%b f=%b m=%b required pc=%h v=%b r=%b f=%b m=%b",
                         step, got.pc, got.valid, got.ready, got.flush, got.mis,
                         want.pc, want.valid, want.ready, want.flush, want.mis);
            end
            step++;
        end
    endtask

    task automatic test_reset_mid();
        obs_t got;
        obs_t want;
        row_t r;
        int   step = 0;
        int   phase;
        // leave HALT via reset, then enter BUBBLE with a payload pending
        rst = 1'b1;
        #1;
        got  = {pc, pc_valid, exe2pc_ready, flush, misaligned};
        want = {32'h1000, 4'b0000};
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL reset_from_halt: got %h required %h", got, want);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (phase = 0; phase < 2; phase++) begin
            if (phase == 0) begin
                sched(0, PC_INC, 32'h0,    32'h0,    32'h0, 1, 32'h1000, 1, 1, 0, 0);
                sched(1, PC_SET, 32'h1000, 32'h5000, 32'h0, 1, 32'h5000, 0, 0, 1, 0);
                sched(1, PC_SET, 32'h5000, 32'h6000, 32'h0, 1, 32'h5000, 0, 0, 0, 0);
            end else begin
                sched(0, PC_INC, 32'h0,    32'h0,    32'h0, 1, 32'h1000, 1, 1, 0, 0);
                sched(0, PC_INC, 32'h0,    32'h0,    32'h0, 1, 32'h1004, 1, 1, 0, 0);
                sched(0, PC_INC, 32'h0,    32'h0,    32'h0, 1, 32'h1008, 1, 1, 0, 0);
            end
            while (plan.size() > 0) begin
                r = plan.pop_front();
                apply(r);
                sb.push_back(r.exp);
                @(posedge clk);
                #1;
                got  = {pc, pc_valid, exe2pc_ready, flush, misaligned};
                want = sb.pop_front();
                tests_run++;
                if (got !== want) begin
                    tests_failed++;
                    $display("FAIL reset_mid step %0d: got pc=%h v=%b r=%b f=%b m=%b required pc=%h v=%b r=%b f=%b m=%b",
                             step, got.pc, got.valid, got.ready, got.flush, got.mis,
                             want.pc, want.valid, want.ready, want.flush, want.mis);
                end
                step++;
            end
            if (phase == 0) begin
                // mid-cycle, inside BUBBLE, payload still valid
                #3;
                rst = 1'b1;
                #1;
                got  = {pc, pc_valid, exe2pc_ready, flush, misaligned};
                want = {32'h1000, 4'b0000};
                tests_run++;
                if (got !== want) begin
                    tests_failed++;
                    $display("FAIL async_reset: got %h required %h", got, want);
                end
                @(posedge clk);
                #1;
                got = {pc, pc_valid, exe2pc_ready, flush, misaligned};
                tests_run++;
                if (got !== want) begin
                    tests_failed++;
                    $display("FAIL reset_held: got %h required %h", got, want);
                end
                rst          = 1'b0;
                exe2pc_valid = 1'b0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_misaligned();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
